// File: rtl/im2col_win_buffer.sv
// rtl/im2col_win_buffer.sv - window-vector FIFO between img2col PU array and MAC array, tags head with col/row position
// Optional same-cycle empty-FIFO bypass under `define IM2COL_WIN_BYPASS_EN.
module im2col_win_buffer #(
   parameter int DATA_WIDTH  = 16,
   parameter int WEIGHT_SIZE = 25,
   parameter int DEPTH       = 4,
   parameter int WIN_COLS    = 24,
   parameter int WIN_ROWS    = 24
) (
   input  logic                      clk,
   input  logic                      nrst,
   input  logic                      clr,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [DATA_WIDTH-1:0]     in_data [WEIGHT_SIZE],
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [DATA_WIDTH-1:0]     out_data [WEIGHT_SIZE],
   output logic [5:0]                out_col,
   output logic [5:0]                out_row,
   output logic                      out_row_last,
   output logic                      out_frame_last,
   output logic [$clog2(DEPTH):0]    level
);

   localparam int         AW         = $clog2(DEPTH);
   localparam logic [5:0] LP_COL_MAX = 6'(WIN_COLS - 1);
   localparam logic [5:0] LP_ROW_MAX = 6'(WIN_ROWS - 1);

   logic [AW:0]           r_wr_ptr;
   logic [AW:0]           r_rd_ptr;
   logic [DATA_WIDTH-1:0] r_mem [DEPTH][WEIGHT_SIZE];
   logic [5:0]            r_col;
   logic [5:0]            r_row;

   logic w_full;
   logic w_empty;
   logic w_bypass;
   logic w_wr_en;
   logic w_rd_en;
   logic w_out_fire;

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   assign w_empty = (r_wr_ptr == r_rd_ptr);
   assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                    (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

`ifdef IM2COL_WIN_BYPASS_EN
   assign w_bypass = w_empty && in_valid && out_ready;
`else
   assign w_bypass = 1'b0;
`endif

   assign in_ready   = !w_full;
   assign out_valid  = !w_empty || w_bypass;
   assign w_wr_en    = in_valid && !w_full && !w_bypass && !clr;
   assign w_rd_en    = !w_empty && out_ready && !clr;
   assign w_out_fire = out_valid && out_ready && !clr;
   assign level      = r_wr_ptr - r_rd_ptr;

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else if (clr) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_rd_en) r_rd_ptr <= r_rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         for (int d = 0; d < DEPTH; d++)
            for (int k = 0; k < WEIGHT_SIZE; k++)
               r_mem[d][k] <= '0;
      end else if (w_wr_en) begin
         for (int k = 0; k < WEIGHT_SIZE; k++)
            r_mem[r_wr_ptr[AW-1:0]][k] <= in_data[k];
      end
   end

   // Position of the head window; only moves when the MAC array takes it.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_col <= '0;
         r_row <= '0;
      end else if (clr) begin
         r_col <= '0;
         r_row <= '0;
      end else if (w_out_fire) begin
         if (r_col == LP_COL_MAX) begin
            r_col <= '0;
            r_row <= (r_row == LP_ROW_MAX) ? 6'd0 : r_row + 6'd1;
         end else begin
            r_col <= r_col + 6'd1;
         end
      end
   end

   always_comb begin
      for (int k = 0; k < WEIGHT_SIZE; k++)
         out_data[k] = w_bypass ? in_data[k] : r_mem[r_rd_ptr[AW-1:0]][k];
   end

   assign out_col        = r_col;
   assign out_row        = r_row;
   assign out_row_last   = (r_col == LP_COL_MAX);
   assign out_frame_last = out_row_last && (r_row == LP_ROW_MAX);

endmodule

// File: tb/tb_im2col_win_buffer.sv
// tb/tb_im2col_win_buffer.sv - self-checking bench for im2col_win_buffer (queue scoreboard plus fill/drain table)
module tb_im2col_win_buffer;

   localparam int DW    = 16;
   localparam int WS    = 25;
   localparam int DEPTH = 4;
   localparam int WC    = 24;
   localparam int WR    = 24;

   typedef struct {
      bit iv;
      bit ordy;
      bit ir;
      bit ov;
      int lvl;
   } vec_t;

   logic          clk;
   logic          nrst;
   logic          clr;
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] in_data [WS];
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] out_data [WS];
   logic [5:0]    out_col;
   logic [5:0]    out_row;
   logic          out_row_last;
   logic          out_frame_last;
   logic [2:0]    level;

   int n_tests;
   int n_fail;
   int q[$];
   int next_id;
   int m_col;
   int m_row;
   int n_out;
   int n_rl;
   int n_fl;
   bit g_fin;

   im2col_win_buffer #(
      .DATA_WIDTH (DW),
      .WEIGHT_SIZE(WS),
      .DEPTH      (DEPTH),
      .WIN_COLS   (WC),
      .WIN_ROWS   (WR)
   ) dut (
      .clk           (clk),
      .nrst          (nrst),
      .clr           (clr),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_data       (in_data),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_data      (out_data),
      .out_col       (out_col),
      .out_row       (out_row),
      .out_row_last  (out_row_last),
      .out_frame_last(out_frame_last),
      .level         (level)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic set_data();
      for (int k = 0; k < WS; k++) in_data[k] = 16'(next_id * 32 + k);
   endtask

   // Called at the falling edge: compare against the model, then update it with this cycle's handshakes.
   task automatic cycle_end();
      bit fin;
      bit fout;
      bit exp_ov;
      int id;
      int bad;
      exp_ov = (q.size() > 0);
`ifdef IM2COL_WIN_BYPASS_EN
      if (q.size() == 0 && in_valid && out_ready) exp_ov = 1'b1;
`endif
      chk("level", int'(level), q.size());
      chk("in_ready", int'(in_ready), int'(q.size() < DEPTH));
      chk("out_valid", int'(out_valid), int'(exp_ov));
      chk("out_col", int'(out_col), m_col);
      chk("out_row", int'(out_row), m_row);
      chk("row_last", int'(out_row_last), int'(m_col == WC - 1));
      chk("frame_last", int'(out_frame_last), int'(m_col == WC - 1 && m_row == WR - 1));
      fin  = in_valid && in_ready;
      fout = out_valid && out_ready;
      if (!nrst || clr) begin
         q.delete();
         m_col = 0;
         m_row = 0;
         fin   = 1'b0;
      end else begin
         if (fin) begin
            q.push_back(next_id);
            next_id++;
         end
         if (fout) begin
            n_out++;
            if (out_row_last) n_rl++;
            if (out_frame_last) n_fl++;
            chk("pop_nonempty", int'(q.size() > 0), 1);
            if (q.size() > 0) begin
               id  = q.pop_front();
               bad = -1;
               for (int k = 0; k < WS; k++)
                  if (bad < 0 && out_data[k] !== 16'(id * 32 + k)) bad = k;
               n_tests++;
               if (bad >= 0) begin
                  n_fail++;
                  $display("FAIL data v%0d elem %0d: got %0d expected %0d",
                           id, bad, out_data[bad], 16'(id * 32 + bad));
               end
            end
            if (m_col == WC - 1) begin
               m_col = 0;
               m_row = (m_row == WR - 1) ? 0 : m_row + 1;
            end else begin
               m_col++;
            end
         end
      end
      g_fin = fin;
      @(posedge clk);
      #1;
      set_data();
   endtask

   task automatic step();
      @(negedge clk);
      cycle_end();
   endtask

   initial begin
      #300000;
      $display("FAIL timeout");
      $fatal(1, "bench timeout");
   end

   initial begin
      vec_t tab[11];
      int   ns;
      int   cyc;
      int   out0, rl0, fl0;

      tab[0]  = '{1, 0, 1, 0, 0};
      tab[1]  = '{1, 0, 1, 1, 1};
      tab[2]  = '{1, 0, 1, 1, 2};
      tab[3]  = '{1, 0, 1, 1, 3};
      tab[4]  = '{1, 0, 0, 1, 4};
      tab[5]  = '{1, 1, 0, 1, 4};
      tab[6]  = '{1, 1, 1, 1, 3};
      tab[7]  = '{0, 1, 1, 1, 3};
      tab[8]  = '{0, 1, 1, 1, 2};
      tab[9]  = '{0, 1, 1, 1, 1};
      tab[10] = '{0, 1, 1, 0, 0};

      n_tests = 0; n_fail = 0; next_id = 0; m_col = 0; m_row = 0;
      n_out = 0; n_rl = 0; n_fl = 0; g_fin = 0;
      clk = 0; nrst = 0; clr = 0; in_valid = 0; out_ready = 0;
      set_data();

      #2;
      chk("rst_in_ready", int'(in_ready), 1);
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_level", int'(level), 0);
      chk("rst_row_last", int'(out_row_last), 0);
      chk("rst_frame_last", int'(out_frame_last), 0);
      chk("rst_out_data", int'(out_data[0]), 0);
      @(posedge clk);
      @(posedge clk);
      #1;
      nrst = 1;
      repeat (10) step();

      // Fill to full with the sink stalled, then drain; the 5th vector is held by the producer.
      for (int i = 0; i < 11; i++) begin
         in_valid  = tab[i].iv;
         out_ready = tab[i].ordy;
         @(negedge clk);
         chk($sformatf("fd%0d_in_ready", i), int'(in_ready), int'(tab[i].ir));
         chk($sformatf("fd%0d_out_valid", i), int'(out_valid), int'(tab[i].ov));
         chk($sformatf("fd%0d_level", i), int'(level), tab[i].lvl);
         cycle_end();
      end
      chk("fd_col_after", int'(out_col), 5);

      // Asynchronous reset in the middle of a cycle with data stored.
      in_valid = 1; out_ready = 0;
      step();
      step();
      nrst = 0;
      q.delete(); m_col = 0; m_row = 0;
      #1;
      chk("arst_level", int'(level), 0);
      chk("arst_out_valid", int'(out_valid), 0);
      chk("arst_col", int'(out_col), 0);
      in_valid = 0;
      step();
      step();
      nrst = 1;
      step();

      // Full frame streaming.
      out0 = n_out; rl0 = n_rl; fl0 = n_fl;
      in_valid = 1; out_ready = 1;
      repeat (WC * WR) step();
      in_valid = 0;
      cyc = 0;
      while (q.size() > 0 && cyc < 10) begin
         step();
         cyc++;
      end
      chk("stream_outputs", n_out - out0, WC * WR);
`ifdef IM2COL_WIN_BYPASS_EN
      chk("stream_drain_cycles", cyc, 0);
`else
      chk("stream_drain_cycles", cyc, 1);
`endif
      chk("stream_row_last", n_rl - rl0, WR);
      chk("stream_frame_last", n_fl - fl0, 1);
      chk("stream_wrap_col", int'(out_col), 0);
      chk("stream_wrap_row", int'(out_row), 0);

      // Random backpressure; producer holds a refused vector.
      in_valid = 0;
      for (int i = 0; i < 400; i++) begin
         if (!in_valid || g_fin) in_valid = 1'($urandom_range(0, 1));
         out_ready = 1'($urandom_range(0, 1));
         @(negedge clk);
         chk("bp_level_bound", int'(level <= 3'd4), 1);
         cycle_end();
      end
      in_valid = 0; out_ready = 1;
      cyc = 0;
      while (q.size() > 0 && cyc < 10) begin
         step();
         cyc++;
      end
      chk("bp_drained", q.size(), 0);

      // clr with a handshake pending on both sides.
      clr = 1;
      step();
      clr = 0;
`ifdef IM2COL_WIN_BYPASS_EN
      ns = 7;
`else
      ns = 8;
`endif
      in_valid = 1; out_ready = 1;
      repeat (ns) step();
      out_ready = 0;
      cyc = 0;
      while (q.size() < 3 && cyc < 8) begin
         step();
         cyc++;
      end
      chk("clr_pre_level", int'(level), 3);
      chk("clr_pre_col", int'(out_col), 7);
      clr = 1; in_valid = 1; out_ready = 1;
      step();
      clr = 0; in_valid = 0; out_ready = 0;
      chk("clr_level", int'(level), 0);
      chk("clr_out_valid", int'(out_valid), 0);
      chk("clr_col", int'(out_col), 0);
      chk("clr_row", int'(out_row), 0);
      step();
      chk("clr_nowrite", int'(level), 0);

      // Empty-FIFO latency: bypass gives same-cycle output, otherwise one cycle.
      in_valid = 1; out_ready = 1;
      @(negedge clk);
`ifdef IM2COL_WIN_BYPASS_EN
      chk("lat_same_cycle_valid", int'(out_valid), 1);
      chk("lat_bypass_data", int'(out_data[0]), int'(in_data[0]));
      chk("lat_bypass_level", int'(level), 0);
`else
      chk("lat_same_cycle_valid", int'(out_valid), 0);
`endif
      cycle_end();
      in_valid = 0;
      @(negedge clk);
`ifdef IM2COL_WIN_BYPASS_EN
      chk("lat_next_cycle_valid", int'(out_valid), 0);
`else
      chk("lat_next_cycle_valid", int'(out_valid), 1);
`endif
      cycle_end();
      repeat (3) step();
      chk("final_empty", q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
